muldiv_execute_unit: RTL and testbench
======================================

MULDIV_EXECUTE_UNIT -- requirements
Module: muldiv_execute_unit

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter NUM_FWD, default 2, number of forwarding sources; FWD_W = $clog2(NUM_FWD+1).
REQ-003 SHALL have parameter NUM_REGS, default 32, register file depth; RW = $clog2(NUM_REGS).
REQ-004 SHALL have port i_aclk  in  1  the single clock.
REQ-005 SHALL have port i_areset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_flush  in  1  synchronous abort of any operation.
REQ-007 SHALL have port i_valid  in  1  request valid.
REQ-008 SHALL have port o_ready  out  1  unit can accept a request.
REQ-009 SHALL have port i_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-010 SHALL have port i_rdest  in  RW  destination register.
REQ-011 SHALL have ports i_forward_a, i_forward_b  in  FWD_W  0 = register operand, k = forward source k.
REQ-012 SHALL have ports i_id_op1, i_id_op2  in  DATA_SIZE  register-file operands.
REQ-013 SHALL have port i_fwd_data  in  NUM_FWD*DATA_SIZE  source k in slice k-1.
REQ-014 SHALL have port o_valid  out  1  result valid.
REQ-015 SHALL have port i_ready  in  1  downstream accepts result.
REQ-016 SHALL have ports o_result (DATA_SIZE), o_rdest (RW)  out  result and its destination.
REQ-017 SHALL have port o_busy  out  1  stall request to hazard unit.

Function
REQ-018 SHALL select each operand combinationally from i_forward_*; any value >NUM_FWD selects the i_id_op* operand.
REQ-019 SHALL use states IDLE, CALC, FIX, DONE; o_ready = (state==IDLE); o_busy = (state==CALC or FIX) or (state==DONE and !i_ready).
REQ-020 SHALL accept on i_valid & o_ready: latch op, rdest, operand magnitudes and result sign; IDLE->CALC with iteration counter 0.
REQ-021 SHALL process one bit per CALC cycle (shift-add multiply over 2*DATA_SIZE product; restoring divide), DATA_SIZE iterations, then CALC->FIX.
REQ-022 SHALL, in FIX, apply two's-complement sign correction, register o_result, then FIX->DONE; normal latency = DATA_SIZE+1 clock edges from the accepting edge.
REQ-023 SHALL return low half for MUL, high half for MULH/MULHSU/MULHU (MULHSU: op1 signed, op2 unsigned).
REQ-024 SHALL give DIV/REM quotient sign = sign(op1) xor sign(op2), remainder sign = sign(op1), truncating toward zero.
REQ-025 SHALL fast-path divisor zero: quotient all-ones, remainder = op1; IDLE->DONE at the accepting edge, latency 1.
REQ-026 SHALL fast-path signed overflow (op1 = most negative, op2 = -1, DIV/REM): quotient = op1, remainder 0, latency 1.
REQ-027 SHALL hold o_valid, o_result, o_rdest stable in DONE until i_ready; DONE->IDLE on i_ready.
REQ-028 SHALL, on i_flush, go to IDLE at the next edge from any state, o_valid low, no result; flush wins over simultaneous accept or i_ready.
REQ-029 SHALL ignore i_valid while o_ready is low; operand/forward inputs are sampled only at accept.

Reset
REQ-030 SHALL, while i_areset high, force state IDLE, counter 0, o_valid 0, o_result 0, o_rdest 0, o_busy 0, o_ready 1, independent of clock.
REQ-031 SHALL abandon any in-flight operation on reset with no result produced after release.

Verification (DATA_SIZE=32, NUM_FWD=2)
REQ-032 MUL op1=7 via forward source 2 (i_id_op1 garbage), op2=-3 -> o_valid 33 cycles after accept, o_result 0xFFFFFFEB.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF latency 1; DIV 0x80000000/-1 -> 0x80000000 latency 1.
REQ-035 Result held with i_ready low 5 cycles -> o_valid, o_result stable, o_busy high, o_ready low; i_ready high -> IDLE next edge.
REQ-036 i_flush 10 cycles into CALC -> no o_valid ever, o_ready 1 next cycle, new DIVU 9/3 returns 3.
REQ-037 i_areset asserted mid-CALC between edges -> outputs at reset values immediately; after release no stale o_valid.

Source files
------------

// File: rtl/muldiv_execute_unit_if.sv
// Request/response bundle for the RV32M multiply/divide execute unit.
// The master side issues operations and consumes results; the unit is the slave.
interface muldiv_execute_unit_if #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned NUM_FWD   = 2,
    parameter int unsigned NUM_REGS  = 32
);
    localparam int unsigned FWD_W = $clog2(NUM_FWD + 1);
    localparam int unsigned RW    = $clog2(NUM_REGS);

    logic                         i_flush;
    logic                         i_valid;
    logic                         o_ready;
    logic [2:0]                   i_op;
    logic [RW-1:0]                i_rdest;
    logic [FWD_W-1:0]             i_forward_a;
    logic [FWD_W-1:0]             i_forward_b;
    logic [DATA_SIZE-1:0]         i_id_op1;
    logic [DATA_SIZE-1:0]         i_id_op2;
    logic [NUM_FWD*DATA_SIZE-1:0] i_fwd_data;
    logic                         o_valid;
    logic                         i_ready;
    logic [DATA_SIZE-1:0]         o_result;
    logic [RW-1:0]                o_rdest;
    logic                         o_busy;

    modport master (
        output i_flush, i_valid, i_op, i_rdest, i_forward_a, i_forward_b,
        output i_id_op1, i_id_op2, i_fwd_data, i_ready,
        input  o_ready, o_valid, o_result, o_rdest, o_busy
    );

    modport slave (
        input  i_flush, i_valid, i_op, i_rdest, i_forward_a, i_forward_b,
        input  i_id_op1, i_id_op2, i_fwd_data, i_ready,
        output o_ready, o_valid, o_result, o_rdest, o_busy
    );
endinterface

// File: rtl/muldiv_execute_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fixed up at the end; divide-by-zero and signed overflow complete immediately.
module muldiv_execute_unit #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned NUM_FWD   = 2,
    parameter int unsigned NUM_REGS  = 32
) (
    input logic                  i_aclk,
    input logic                  i_areset,
    muldiv_execute_unit_if.slave bus
);
    localparam int unsigned FWD_W = $clog2(NUM_FWD + 1);
    localparam int unsigned RW    = $clog2(NUM_REGS);
    localparam int unsigned N     = DATA_SIZE;
    localparam int unsigned CW    = $clog2(DATA_SIZE);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [RW-1:0]   rdest_q;
    logic            res_neg_q;
    logic [N-1:0]    hi_q, lo_q, opb_q;
    logic [N-1:0]    result_q;

    logic [N-1:0]    op_a, op_b, mag_a, mag_b, fast_result;
    logic            a_signed, b_signed, a_neg, b_neg, res_neg;
    logic            is_div, rem_sel, div_zero, div_ovf, fast, accept;

    always_comb begin
        op_a = bus.i_id_op1;
        op_b = bus.i_id_op2;
        for (int unsigned k = 1; k <= NUM_FWD; k++) begin
            if (bus.i_forward_a == FWD_W'(k)) op_a = bus.i_fwd_data[(k-1)*N +: N];
            if (bus.i_forward_b == FWD_W'(k)) op_b = bus.i_fwd_data[(k-1)*N +: N];
        end
    end

    // MUL is run unsigned: its low half does not depend on operand signedness.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.i_op)
            3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
    end

    assign is_div   = bus.i_op[2];
    assign rem_sel  = bus.i_op[1];
    assign a_neg    = a_signed & op_a[N-1];
    assign b_neg    = b_signed & op_b[N-1];
    assign mag_a    = a_neg ? -op_a : op_a;
    assign mag_b    = b_neg ? -op_b : op_b;
    assign res_neg  = (is_div & rem_sel) ? a_neg : (a_neg ^ b_neg);
    assign div_zero = is_div & (op_b == '0);
    assign div_ovf  = is_div & ~bus.i_op[0] & (op_a == {1'b1, {(N-1){1'b0}}}) & (&op_b);
    assign fast     = div_zero | div_ovf;
    assign fast_result = div_zero ? (rem_sel ? op_a : '1) : (rem_sel ? '0 : op_a);
    assign accept   = bus.i_valid & (state_q == StIdle) & ~bus.i_flush;

    // Multiply: {hi,lo} shifts right with lo holding the multiplier.
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient in.
    logic [N:0]      mul_sum, div_sh, div_diff;
    logic            div_ge;
    logic [N-1:0]    hi_step, lo_step, div_val, div_fix, fix_result;
    logic [2*N-1:0]  prod, prod_fix;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {hi_q, lo_q[N-1]};
        div_ge   = div_sh >= {1'b0, opb_q};
        div_diff = div_sh - {1'b0, opb_q};
        if (op_q[2]) begin
            hi_step = div_ge ? div_diff[N-1:0] : div_sh[N-1:0];
            lo_step = {lo_q[N-2:0], div_ge};
        end else begin
            hi_step = mul_sum[N:1];
            lo_step = {mul_sum[0], lo_q[N-1:1]};
        end
    end

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = res_neg_q ? -prod : prod;
        div_val  = op_q[1] ? hi_q : lo_q;
        div_fix  = res_neg_q ? -div_val : div_val;
        if (op_q[2])              fix_result = div_fix;
        else if (op_q[1:0] == '0) fix_result = prod_fix[N-1:0];
        else                      fix_result = prod_fix[2*N-1:N];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = fast ? StDone : StCalc;
            StCalc: if (cnt_q == CW'(N - 1)) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: if (bus.i_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.i_flush) state_d = StIdle;
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            cnt_q     <= '0;
            op_q      <= '0;
            rdest_q   <= '0;
            res_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                StIdle: if (accept) begin
                    op_q      <= bus.i_op;
                    rdest_q   <= bus.i_rdest;
                    res_neg_q <= res_neg;
                    hi_q      <= '0;
                    lo_q      <= mag_a;
                    opb_q     <= mag_b;
                    cnt_q     <= '0;
                    if (fast) result_q <= fast_result;
                end
                StCalc: begin
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q + CW'(1);
                end
                StFix:   result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign bus.o_ready  = (state_q == StIdle);
    assign bus.o_valid  = (state_q == StDone);
    assign bus.o_busy   = (state_q == StCalc) || (state_q == StFix) ||
                          ((state_q == StDone) && !bus.i_ready);
    assign bus.o_result = result_q;
    assign bus.o_rdest  = rdest_q;
endmodule

// File: tb/tb_muldiv_execute_unit.sv
// Directed bench for muldiv_execute_unit (DATA_SIZE=32, NUM_FWD=2) with
// hand-computed results, latencies, hold, flush and reset behaviour.
module tb_muldiv_execute_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned NF = 2;
    localparam int unsigned NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    muldiv_execute_unit_if #(.DATA_SIZE(DW), .NUM_FWD(NF), .NUM_REGS(NR)) bus ();

    muldiv_execute_unit #(.DATA_SIZE(DW), .NUM_FWD(NF), .NUM_REGS(NR)) dut (
        .i_aclk  (clk),
        .i_areset(rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns 1ns after the accepting edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] fa, input logic [1:0] fb,
                            input logic [63:0] fdata, input logic [4:0] rd);
        bus.i_op        = op;
        bus.i_id_op1    = a;
        bus.i_id_op2    = b;
        bus.i_forward_a = fa;
        bus.i_forward_b = fb;
        bus.i_fwd_data  = fdata;
        bus.i_rdest     = rd;
        bus.i_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid     = 1'b0;
        bus.i_op        = 3'($urandom);
        bus.i_id_op1    = $urandom;
        bus.i_id_op2    = $urandom;
        bus.i_fwd_data  = {$urandom, $urandom};
        bus.i_forward_a = 2'($urandom);
        bus.i_forward_b = 2'($urandom);
        bus.i_rdest     = 5'($urandom);
    endtask

    // Latency is counted in clock edges after the accepting edge.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic [63:0] fdata, input logic [4:0] rd,
                          input int exp_lat, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        start_op(op, a, b, fa, fb, fdata, rd);
        @(negedge clk);
        while (!bus.o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/lat"}, 32'(n), 32'(exp_lat));
        check({tag, "/res"}, bus.o_result, exp);
        check({tag, "/rd"}, {27'd0, bus.o_rdest}, {27'd0, rd});
    endtask

    task automatic retire(input string tag);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        @(negedge clk);
        check({tag, "/idle"}, {31'd0, bus.o_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw;
        bus.i_flush = 0; bus.i_valid = 0; bus.i_ready = 0; bus.i_op = 0; bus.i_rdest = 0;
        bus.i_forward_a = 0; bus.i_forward_b = 0;
        bus.i_id_op1 = 0; bus.i_id_op2 = 0; bus.i_fwd_data = 0;

        #2 rst = 1'b1;
        #1;
        check("rst/ready", {31'd0, bus.o_ready}, 32'd1);
        check("rst/valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst/busy",  {31'd0, bus.o_busy},  32'd0);
        check("rst/res",   bus.o_result, 32'd0);
        check("rst/rd",    {27'd0, bus.o_rdest}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // op1 from forward source 2 while i_id_op1 carries garbage
        run_op("mul_fwd", 3'd0, 32'hDEADBEEF, 32'hFFFFFFFD, 2'd2, 2'd0,
               {32'd7, 32'h12345678}, 5'd5, 33, 32'hFFFFFFEB);
        retire("mul_fwd");

        run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 2'd0, 64'd0, 5'd6,
               33, 32'hFFFFFFFE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold/valid", {31'd0, bus.o_valid}, 32'd1);
            check("hold/res",   bus.o_result, 32'hFFFFFFFE);
            check("hold/busy",  {31'd0, bus.o_busy}, 32'd1);
            check("hold/ready", {31'd0, bus.o_ready}, 32'd0);
        end
        retire("mulhu");

        run_op("mulh", 3'd1, 32'h80000000, 32'h80000000, 2'd0, 2'd0, 64'd0, 5'd7,
               33, 32'h40000000);
        retire("mulh");
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 2'd0, 2'd0, 64'd0, 5'd8,
               33, 32'hFFFFFFFF);
        retire("mulhsu");
        // forward select 3 exceeds NUM_FWD, so the register operand is used
        run_op("mul_lo", 3'd0, 32'h12345678, 32'h10, 2'd3, 2'd3, 64'hAAAA_AAAA_5555_5555,
               5'd9, 33, 32'h23456780);
        retire("mul_lo");
        run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 2'd0, 2'd0, 64'd0, 5'd10, 33, 32'hFFFFFFFD);
        retire("div");
        run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 2'd0, 2'd0, 64'd0, 5'd11, 33, 32'hFFFFFFFF);
        retire("rem");
        run_op("rem_pos", 3'd6, 32'd7, 32'hFFFFFFFE, 2'd0, 2'd0, 64'd0, 5'd12, 33, 32'd1);
        retire("rem_pos");
        // divisor from forward source 1
        run_op("divu_fwd", 3'd5, 32'hFFFFFFFF, 32'd0, 2'd0, 2'd1, {32'd0, 32'h10}, 5'd13,
               33, 32'h0FFFFFFF);
        retire("divu_fwd");
        run_op("remu", 3'd7, 32'hFFFFFFFF, 32'h10, 2'd0, 2'd0, 64'd0, 5'd14, 33, 32'hF);
        retire("remu");

        run_op("divu_z", 3'd5, 32'd100, 32'd0, 2'd0, 2'd0, 64'd0, 5'd15, 0, 32'hFFFFFFFF);
        retire("divu_z");
        run_op("remu_z", 3'd7, 32'd100, 32'd0, 2'd0, 2'd0, 64'd0, 5'd16, 0, 32'd100);
        retire("remu_z");
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 2'd0, 2'd0, 64'd0, 5'd17,
               0, 32'h80000000);
        retire("div_ovf");
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 2'd0, 2'd0, 64'd0, 5'd18,
               0, 32'd0);
        retire("rem_ovf");

        // flush mid-calculation: nothing comes out, and the unit is usable again
        @(negedge clk);
        start_op(3'd5, 32'd1000, 32'd7, 2'd0, 2'd0, 64'd0, 5'd19);
        repeat (10) @(negedge clk);
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1 bus.i_flush = 1'b0;
        @(negedge clk);
        check("flush/ready", {31'd0, bus.o_ready}, 32'd1);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_valid) saw = 1'b1;
        end
        check("flush/noval", {31'd0, saw}, 32'd0);
        run_op("divu_post", 3'd5, 32'd9, 32'd3, 2'd0, 2'd0, 64'd0, 5'd20, 33, 32'd3);
        retire("divu_post");

        // flush beats a simultaneous request
        @(negedge clk);
        bus.i_op = 3'd0; bus.i_id_op1 = 32'd3; bus.i_id_op2 = 32'd3;
        bus.i_forward_a = 0; bus.i_forward_b = 0;
        bus.i_valid = 1'b1; bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        @(negedge clk);
        check("flushacc/ready", {31'd0, bus.o_ready}, 32'd1);
        check("flushacc/busy",  {31'd0, bus.o_busy},  32'd0);

        // asynchronous reset between edges in the middle of a calculation
        @(negedge clk);
        start_op(3'd0, 32'd5, 32'd6, 2'd0, 2'd0, 64'd0, 5'd21);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst/valid", {31'd0, bus.o_valid}, 32'd0);
        check("arst/ready", {31'd0, bus.o_ready}, 32'd1);
        check("arst/busy",  {31'd0, bus.o_busy},  32'd0);
        check("arst/res",   bus.o_result, 32'd0);
        check("arst/rd",    {27'd0, bus.o_rdest}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_valid) saw = 1'b1;
        end
        check("arst/noval", {31'd0, saw}, 32'd0);
        check("arst/idle",  {31'd0, bus.o_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
